// File: rtl/bnn_pkg.sv
// Shared types, constants and the matrix-size clamp helper for the BNN sequencer.
package bnn_pkg;

  localparam int unsigned BNN_WORD_W = 32;
  localparam int unsigned BNN_MAX_MS = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bnn_state_t;

  // A zero size means one word; anything above the maximum saturates.
  function automatic logic [BNN_WORD_W-1:0] bnn_clamp_ms(input logic [BNN_WORD_W-1:0] w,
                                                         input logic [BNN_WORD_W-1:0] max_ms);
    if (w == '0) return 32'd1;
    else if (w > max_ms) return max_ms;
    else return w;
  endfunction

endpackage

// File: rtl/bnn_sequencer_if.sv
// Execute-side bus of the BNN sequencer: size write, start/flush, operand fetch, result.
interface bnn_sequencer_if #(
  parameter int unsigned MAX_MS = bnn_pkg::BNN_MAX_MS
);
  localparam int unsigned IDX_W = $clog2(MAX_MS);

  logic              ms_we;
  logic [31:0]       ms_wdata;
  logic              start;
  logic              flush;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [IDX_W-1:0]  idx;
  logic              op_req;
  logic              busy;
  logic              stall_req;
  logic              done;
  logic [31:0]       result;

  modport master (
    output ms_we, ms_wdata, start, flush, op_a, op_b,
    input  idx, op_req, busy, stall_req, done, result
  );

  modport slave (
    input  ms_we, ms_wdata, start, flush, op_a, op_b,
    output idx, op_req, busy, stall_req, done, result
  );

endinterface

// File: rtl/bnn_popcount.sv
// Combinational 32-bit population count built as a five-level adder tree.
module bnn_popcount
  import bnn_pkg::*;
(
  input  logic [BNN_WORD_W-1:0] word_i,
  output logic [5:0]            count_o
);

  logic [1:0] l1 [16];
  logic [2:0] l2 [8];
  logic [3:0] l3 [4];
  logic [4:0] l4 [2];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) l1[i] = {1'b0, word_i[2*i]} + {1'b0, word_i[2*i+1]};
    for (int unsigned i = 0; i < 8; i++)  l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    for (int unsigned i = 0; i < 4; i++)  l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
    for (int unsigned i = 0; i < 2; i++)  l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
    count_o = {1'b0, l4[0]} + {1'b0, l4[1]};
  end

endmodule

// File: rtl/bnn_sequencer.sv
// BNN XNOR-popcount sequencer: walks ms_act word pairs and returns the bipolar dot product.
// Define BNN_SIGN_ACT_EN to return the binarized sign activation instead of the sum.
module bnn_sequencer
  import bnn_pkg::*;
#(
  parameter int unsigned MAX_MS = BNN_MAX_MS
) (
  input logic            clk,
  input logic            reset,
  bnn_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MAX_MS);
  localparam int unsigned MS_W  = IDX_W + 1;
  localparam int unsigned ACC_W = $clog2(MAX_MS * 32) + 1;

  bnn_state_t        state_q, state_d;
  logic [MS_W-1:0]   ms_reg_q, ms_reg_d;
  logic [MS_W-1:0]   ms_act_q, ms_act_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       result_q, result_d;

  logic [MS_W-1:0]   ms_wr;
  logic [5:0]        pop;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W:0]    diff;
  logic [31:0]       res_calc;
  logic              last;
  logic              op_req, stall_req, done;

  bnn_popcount u_pop (
    .word_i  (~(bus.op_a ^ bus.op_b)),
    .count_o (pop)
  );

  assign ms_wr   = MS_W'(bnn_clamp_ms(bus.ms_wdata, 32'(MAX_MS)));
  assign acc_sum = acc_q + ACC_W'(pop);
  assign last    = ({1'b0, idx_q} == ms_act_q - 1'b1);
  // 2*acc - 32*ms computed modulo 2^(ACC_W+1); the true value always fits signed.
  assign diff    = {acc_sum, 1'b0} - (ACC_W+1)'({ms_act_q, 5'b0});

`ifdef BNN_SIGN_ACT_EN
  assign res_calc = {31'b0, ~diff[ACC_W]};
`else
  assign res_calc = {{(31 - ACC_W){diff[ACC_W]}}, diff};
`endif

  always_comb begin
    state_d   = state_q;
    ms_reg_d  = bus.ms_we ? ms_wr : ms_reg_q;
    ms_act_d  = ms_act_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    result_d  = result_q;
    op_req    = 1'b0;
    stall_req = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_req = bus.start & ~bus.flush;
        if (bus.start && !bus.flush) begin
          state_d  = RUN;
          acc_d    = '0;
          idx_d    = '0;
          ms_act_d = bus.ms_we ? ms_wr : ms_reg_q;
        end
      end
      RUN: begin
        op_req    = 1'b1;
        stall_req = 1'b1;
        acc_d     = acc_sum;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (last) begin
          state_d  = DONE;
          result_d = res_calc;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        done    = ~bus.flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ms_reg_q <= MS_W'(1);
      ms_act_q <= MS_W'(1);
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ms_reg_q <= ms_reg_d;
      ms_act_q <= ms_act_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign bus.idx       = idx_q;
  assign bus.op_req    = op_req;
  assign bus.busy      = (state_q != IDLE);
  assign bus.stall_req = stall_req;
  assign bus.done      = done;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Scoreboard bench for bnn_sequencer: randomized operands, reference dot product per operation.
module tb_bnn_sequencer;

  localparam int unsigned MS_MAX = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_sequencer_if #(.MAX_MS(MS_MAX)) bus ();

  bnn_sequencer #(.MAX_MS(MS_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] a_mem [MS_MAX];
  logic [31:0] b_mem [MS_MAX];
  logic [31:0] exp_q [$];
  int          ms_model;
  logic [31:0] last_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int unsigned w);
    if (w == 0) return 1;
    if (w > MS_MAX) return MS_MAX;
    return int'(w);
  endfunction

  // Bipolar dot product: each matching bit contributes +1, each differing bit -1.
  function automatic logic [31:0] ref_result(input int ms);
    int sum;
    sum = 0;
    for (int i = 0; i < ms; i++) sum += $countones(~(a_mem[i] ^ b_mem[i]));
`ifdef BNN_SIGN_ACT_EN
    return (2 * sum >= 32 * ms) ? 32'd1 : 32'd0;
`else
    return 32'(2 * sum - 32 * ms);
`endif
  endfunction

  // Operand memory: answers the index presented by the sequencer in the same cycle.
  initial begin
    forever begin
      @(negedge clk);
      bus.op_a = a_mem[bus.idx];
      bus.op_b = b_mem[bus.idx];
    end
  end

  // Result monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: done=1 with no operation pending, required 0");
        end else begin
          check("result", bus.result, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_op(input bit we, input int unsigned wdata, input int pat,
                       input int flush_at, input int reset_at,
                       input int mid_at, input int unsigned mid_wdata);
    int          ms;
    logic [31:0] exp;
    bit          aborted;
    aborted = 0;
    for (int i = 0; i < MS_MAX; i++) begin
      case (pat)
        1:       begin a_mem[i] = 32'hFFFF_FFFF; b_mem[i] = 32'hFFFF_FFFF; end
        2:       begin a_mem[i] = 32'h0000_0000; b_mem[i] = 32'hFFFF_FFFF; end
        default: begin a_mem[i] = $urandom; b_mem[i] = ($urandom_range(0, 3) == 0) ? a_mem[i] : $urandom; end
      endcase
    end
    @(negedge clk);
    if (we) ms_model = clamp(wdata);
    ms  = ms_model;
    exp = ref_result(ms);
    if (flush_at < 0 && reset_at < 0) exp_q.push_back(exp);
    bus.ms_we    = we;
    bus.ms_wdata = wdata;
    bus.start    = 1'b1;
    #1;
    check("stall_on_start", 32'(bus.stall_req), 32'd1);
    check("busy_before_run", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.ms_we = 1'b0;
    for (int k = 0; k < ms; k++) begin
      check("op_req", 32'(bus.op_req), 32'd1);
      check("idx", 32'(bus.idx), 32'(k));
      check("stall_run", 32'(bus.stall_req), 32'd1);
      check("done_early", 32'(bus.done), 32'd0);
      if (k == mid_at) begin
        bus.ms_we    = 1'b1;
        bus.ms_wdata = mid_wdata;
        bus.start    = 1'b1;
        ms_model     = clamp(mid_wdata);
      end
      if (k == flush_at) bus.flush = 1'b1;
      if (k == reset_at) reset = 1'b1;
      @(negedge clk);
      bus.ms_we = 1'b0;
      bus.start = 1'b0;
      if (k == flush_at) begin
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_op_req", 32'(bus.op_req), 32'd0);
        check("flush_no_done", 32'(bus.done), 32'd0);
        check("flush_result_kept", bus.result, last_res);
        aborted = 1;
        break;
      end
      if (k == reset_at) begin
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_op_req", 32'(bus.op_req), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_stall", 32'(bus.stall_req), 32'd0);
        check("rst_idx", 32'(bus.idx), 32'd0);
        check("rst_result", bus.result, 32'd0);
        ms_model = 1;
        last_res = '0;
        aborted  = 1;
        break;
      end
    end
    if (!aborted) begin
      check("done_pulse", 32'(bus.done), 32'd1);
      check("stall_in_done", 32'(bus.stall_req), 32'd0);
      check("op_req_in_done", 32'(bus.op_req), 32'd0);
      check("idx_hold", 32'(bus.idx), 32'(ms - 1));
      last_res = exp;
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("idle_after_done", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.ms_we    = 1'b0;
    bus.ms_wdata = '0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    for (int i = 0; i < MS_MAX; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    ms_model = 1;
    last_res = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_op_req", 32'(bus.op_req), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_idx", 32'(bus.idx), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_stall", 32'(bus.stall_req), 32'd0);
    reset = 1'b0;

    do_op(1, 4, 1, -1, -1, -1, 0);    // all-match, 4 words
    do_op(1, 2, 2, -1, -1, -1, 0);    // all-mismatch, 2 words
    do_op(1, 0, 0, -1, -1, -1, 0);    // size 0 clamps to 1
    do_op(1, 100, 0, -1, -1, -1, 0);  // size clamps to 16
    do_op(1, 8, 0, 2, -1, -1, 0);     // flush in third RUN cycle
    do_op(0, 0, 0, -1, -1, -1, 0);
    do_op(1, 3, 0, -1, -1, 1, 5);     // size write and start mid-RUN
    do_op(0, 0, 0, -1, -1, -1, 0);
    do_op(1, 6, 0, -1, 2, -1, 0);     // reset mid-RUN
    do_op(0, 0, 0, -1, -1, -1, 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    check("start_flush_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start_flush_idle", 32'(bus.busy), 32'd0);

    for (int n = 0; n < 24; n++) begin
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, 20), 0, -1, -1, -1, 0);
    end

    repeat (3) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
